// File: rtl/frame_scheduler.sv
// Packs pre-emphasis output into ping-pong frame banks and offers full banks with valid/ack.
// Latency: adc_valid -> buffer write PE_LATENCY+1 cycles; last write -> frame_valid +1 cycle. Overruns are dropped and flagged.
module frame_scheduler #(
    parameter int FRAME_LEN  = 256,
    parameter int ADDR_W     = $clog2(FRAME_LEN),
    parameter int PE_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              adc_valid,
    input  logic [15:0]       pe_sample,
    output logic              buf_wr_en,
    output logic [ADDR_W:0]   buf_wr_addr,
    output logic [15:0]       buf_wr_data,
    output logic              frame_valid,
    output logic              frame_bank,
    input  logic              frame_ack,
    output logic [15:0]       frame_count,
    output logic              overflow
);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_STALL} state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

    state_t              state_q, state_d;
    logic [PE_LATENCY-1:0] cap_sr;
    logic                cap;
    logic [1:0]          full_q, full_d;
    logic                fill_bank_q, fill_bank_d;
    logic                rd_bank_q, rd_bank_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic                done_q, done_bank_q, frame_done;
    logic                do_write, do_drop;

    assign cap = cap_sr[PE_LATENCY-1];

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next state looks at post-update bank status, so an ack frees a stalled bank for the next cycle
    always_comb begin
        state_d = S_IDLE;
        if (enable) state_d = full_d[fill_bank_d] ? S_STALL : S_FILL;
    end

    // Output decode: the registered state decides the fate of this cycle's cap
    always_comb begin
        do_write = 1'b0;
        do_drop  = 1'b0;
        case (state_q)
            S_FILL:  do_write = cap;
            S_STALL: do_drop  = cap;
            default: ;
        endcase
    end

    always_comb begin
        full_d      = full_q;
        fill_bank_d = fill_bank_q;
        rd_bank_d   = rd_bank_q;
        wr_ptr_d    = wr_ptr_q;
        frame_done  = 1'b0;
        if (do_write) begin
            if (wr_ptr_q == LAST_IDX) begin
                wr_ptr_d    = '0;
                fill_bank_d = ~fill_bank_q;
                frame_done  = 1'b1;
            end else begin
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            end
        end
        if (!enable) wr_ptr_d = '0;
        // Completion is committed one cycle after the cap, aligned with the buffer write
        if (done_q) full_d[done_bank_q] = 1'b1;
        if (frame_ack && frame_valid) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_sr      <= '0;
            full_q      <= '0;
            fill_bank_q <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_ptr_q    <= '0;
            done_q      <= 1'b0;
            done_bank_q <= 1'b0;
            buf_wr_en   <= 1'b0;
            buf_wr_addr <= '0;
            buf_wr_data <= '0;
            frame_valid <= 1'b0;
            frame_bank  <= 1'b0;
            frame_count <= '0;
            overflow    <= 1'b0;
        end else begin
            cap_sr      <= (cap_sr << 1) | PE_LATENCY'(adc_valid);
            full_q      <= full_d;
            fill_bank_q <= fill_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_ptr_q    <= wr_ptr_d;
            done_q      <= frame_done;
            done_bank_q <= fill_bank_q;
            buf_wr_en   <= do_write;
            if (do_write) begin
                buf_wr_addr <= {fill_bank_q, wr_ptr_q};
                buf_wr_data <= pe_sample;
            end
            frame_valid <= full_d[rd_bank_d];
            frame_bank  <= rd_bank_d;
            if (done_q)  frame_count <= frame_count + 16'd1;
            if (do_drop) overflow    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_frame_scheduler.sv
// Directed bench for frame_scheduler (FRAME_LEN=4): scoreboarded buffer writes plus status checks.
module tb_frame_scheduler;
    localparam int FL = 4;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst, enable, adc_valid, frame_ack;
    logic [15:0]   pe_sample;
    logic          buf_wr_en;
    logic [AW:0]   buf_wr_addr;
    logic [15:0]   buf_wr_data;
    logic          frame_valid, frame_bank, overflow;
    logic [15:0]   frame_count;

    typedef struct packed {
        logic [AW:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  tests = 0;
    int  fails = 0;

    always #5 clk = ~clk;

    frame_scheduler #(.FRAME_LEN(FL), .ADDR_W(AW), .PE_LATENCY(1)) dut (
        .clk(clk), .rst(rst), .enable(enable), .adc_valid(adc_valid),
        .pe_sample(pe_sample), .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr),
        .buf_wr_data(buf_wr_data), .frame_valid(frame_valid), .frame_bank(frame_bank),
        .frame_ack(frame_ack), .frame_count(frame_count), .overflow(overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every buffer write must match the oldest expected write
    always @(negedge clk) begin : mon
        wr_t e;
        if (buf_wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: addr=%0d data=0x%0h, no write expected at %0t",
                         buf_wr_addr, buf_wr_data, $time);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(buf_wr_addr), 32'(e.addr));
                check("wr_data", 32'(buf_wr_data), 32'(e.data));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // adc_valid in cycle k, filtered value on pe_sample in k+1; returns in k+2 when the write is visible
    task automatic sample(input logic [15:0] d, input bit wr, input logic [AW:0] a);
        adc_valid = 1'b1;
        step();
        adc_valid = 1'b0;
        pe_sample = d;
        if (wr) exp_q.push_back('{addr: a, data: d});
        step();
    endtask

    task automatic ack();
        frame_ack = 1'b1;
        step();
        frame_ack = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en"},   32'(buf_wr_en),   0);
        check({tag, "_wr_addr"}, 32'(buf_wr_addr), 0);
        check({tag, "_wr_data"}, 32'(buf_wr_data), 0);
        check({tag, "_fvalid"},  32'(frame_valid), 0);
        check({tag, "_fbank"},   32'(frame_bank),  0);
        check({tag, "_fcount"},  32'(frame_count), 0);
        check({tag, "_ovf"},     32'(overflow),    0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; enable = 1'b0; adc_valid = 1'b0; frame_ack = 1'b0; pe_sample = 16'h0;
        repeat (3) step();
        check_all_zero("reset");
        rst = 1'b0;
        enable = 1'b1;
        repeat (3) step();

        // Latency/alignment, then discard the one-sample partial frame
        sample(16'h1234, 1'b1, 3'd0);
        enable = 1'b0; step();
        enable = 1'b1; step(); step();

        // Frame completion into bank 0
        for (int i = 0; i < FL; i++) sample(16'(i + 1), 1'b1, 3'(i));
        step();
        check("fc1_fvalid", 32'(frame_valid), 1);
        check("fc1_fbank",  32'(frame_bank),  0);
        check("fc1_fcount", 32'(frame_count), 1);

        // Ping-pong into bank 1 without ack
        for (int i = 0; i < FL; i++) sample(16'(i + 5), 1'b1, 3'(4 + i));
        step();
        check("pp_fcount", 32'(frame_count), 2);
        check("pp_fbank",  32'(frame_bank),  0);

        // Overflow with both banks full
        sample(16'd9, 1'b0, 3'd0);
        check("ovf_no_write", 32'(buf_wr_en), 0);
        check("ovf_flag",     32'(overflow),  1);
        check("ovf_fcount",   32'(frame_count), 2);
        ack();
        check("ack1_fvalid", 32'(frame_valid), 1);
        check("ack1_fbank",  32'(frame_bank),  1);
        sample(16'd10, 1'b1, 3'd0);
        check("ovf_sticky", 32'(overflow), 1);
        ack();
        check("ack2_fvalid", 32'(frame_valid), 0);

        // Partial discard: bank 0 holds 2 samples, enable drops for a cycle
        sample(16'd11, 1'b1, 3'd1);
        enable = 1'b0; step();
        enable = 1'b1; step(); step();
        for (int i = 0; i < FL; i++) sample(16'(21 + i), 1'b1, 3'(i));
        step();
        check("pd_fcount", 32'(frame_count), 3);
        check("pd_fvalid", 32'(frame_valid), 1);
        check("pd_fbank",  32'(frame_bank),  0);

        // Reset mid-frame with a frame on offer
        for (int i = 0; i < 3; i++) sample(16'(31 + i), 1'b1, 3'(4 + i));
        rst = 1'b1;
        step();
        check_all_zero("midrst");
        rst = 1'b0;
        step(); step();
        for (int i = 0; i < FL; i++) sample(16'(41 + i), 1'b1, 3'(i));
        step();
        check("rr_fcount", 32'(frame_count), 1);
        check("rr_fvalid", 32'(frame_valid), 1);
        check("rr_fbank",  32'(frame_bank),  0);
        check("rr_ovf",    32'(overflow),    0);

        // enable falls in the same cycle as the completing cap: frame is kept
        for (int i = 0; i < 3; i++) sample(16'(51 + i), 1'b1, 3'(4 + i));
        adc_valid = 1'b1;
        step();
        adc_valid = 1'b0;
        pe_sample = 16'd54;
        enable = 1'b0;
        exp_q.push_back('{addr: 3'd7, data: 16'd54});
        step();
        step();
        check("ef_fcount", 32'(frame_count), 2);
        ack();
        check("ef_fvalid", 32'(frame_valid), 1);
        check("ef_fbank",  32'(frame_bank),  1);
        ack();
        check("ef_fvalid2", 32'(frame_valid), 0);

        repeat (3) step();
        check("queue_empty", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/frame_scheduler.md
# frame_scheduler

Sequences the pre-emphasis stage output into fixed-length frames for the feature-extraction back end (windowing/FFT/MFCC). It aligns the ADC sample strobe to the pre-emphasis filter's one-cycle latency and writes each filtered sample into a two-bank (ping-pong) frame buffer. It hands completed banks to the downstream consumer with a valid/ack handshake. Filling one bank while the consumer reads the other gives gapless capture; overruns are dropped and flagged.

## Interface
Parameters:
- FRAME_LEN, 256, samples per frame; any value ≥ 2.
- ADDR_W, $clog2(FRAME_LEN), in-bank address width.
- PE_LATENCY, 1, cycles from a sample entering pre-emphasis to its filtered value on pe_sample.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  capture enable; low discards any partial frame.
- adc_valid  in  1  one-cycle strobe; new raw sample presented to pre-emphasis this cycle.
- pe_sample  in  16  pre-emphasis filter output.
- buf_wr_en  out  1  frame buffer write strobe.
- buf_wr_addr  out  ADDR_W+1  {bank, index}; MSB selects bank.
- buf_wr_data  out  16  sample to write.
- frame_valid  out  1  a full bank is ready for the consumer.
- frame_bank  out  1  bank being offered; stable while frame_valid is high.
- frame_ack  in  1  consumer finished with frame_bank; single-cycle pulse.
- frame_count  out  16  completed frames since reset; wraps at 2^16.
- overflow  out  1  sticky flag: at least one sample was dropped.

## Operation
- Capture strobe: cap = adc_valid delayed by PE_LATENCY cycles through a shift register. A cap in cycle c means pe_sample holds the filtered sample in cycle c.
- Per-bank status is FREE or FULL. Registers: fill_bank, wr_ptr[ADDR_W-1:0], rd_bank.
- FSM states:
  - IDLE: enable low. wr_ptr held at 0. Caps ignored. FULL banks stay offered.
  - FILL: enable high and the fill_bank bank is FREE.
  - STALL: enable high and the fill_bank bank is FULL.
- FSM transitions:
  - IDLE→FILL or STALL when enable rises.
  - Any state→IDLE when enable falls; wr_ptr is cleared and the partial frame is discarded.
  - STALL→FILL when the ack frees the fill bank.
- Cap in FILL:
  - Register a write: buf_wr_en=1, buf_wr_addr={fill_bank, wr_ptr}, buf_wr_data=pe_sample.
  - Then wr_ptr++.
  - If wr_ptr was FRAME_LEN-1: mark fill_bank FULL, set wr_ptr to 0, toggle fill_bank, increment frame_count.
- Cap in STALL:
  - No write. Sample dropped, overflow set to 1. wr_ptr unchanged.
- Cap in IDLE: no write, no flag.
- Offer logic:
  - frame_valid = bank rd_bank is FULL; frame_bank = rd_bank.
  - frame_ack while frame_valid is high marks rd_bank FREE and toggles rd_bank.
  - frame_ack while frame_valid is low is ignored.
- Frames are offered strictly in completion order, bank 0 first after reset.
- Simultaneous events:
  - Ack and frame completion in the same cycle: both take effect. An ack freeing the current fill_bank in the same cycle as a cap still drops that cap (status is evaluated before update).
  - enable falling in the same cycle as a completing cap: the frame completes and is kept.
- Reset: every output is 0. Both banks FREE, fill_bank=0, rd_bank=0, wr_ptr=0, delay line cleared, FSM in IDLE.
- overflow clears only on rst.

## Timing
- adc_valid in cycle t → cap in cycle t+PE_LATENCY → buf_wr_* valid in cycle t+PE_LATENCY+1, for exactly one cycle.
- Last write of a frame in cycle w:
  - frame_valid rises in w+1 if that bank is now rd_bank.
  - frame_count shows the new value in w+1.
- frame_ack in cycle a → in a+1, frame_valid is low, or stays high with frame_bank toggled if the other bank is also FULL.
- Throughput: one sample per cycle sustained (adc_valid every cycle) while the consumer acks within FRAME_LEN samples.
- All outputs are registered. No combinational path from inputs to outputs.

## Test plan
All scenarios use FRAME_LEN=4, PE_LATENCY=1.
- Latency/alignment: after rst, set enable=1 and pulse adc_valid at t=10; drive pe_sample=0x1234 at t=11 → buf_wr_en=1, addr=0, data=0x1234 at t=12 and at no other cycle.
- Frame completion: 4 caps with pe_sample 1,2,3,4 → writes to addr 0..3. frame_valid=1 and frame_bank=0 the cycle after the 4th write; frame_count=1.
- Ping-pong: 4 more caps without ack → writes to addr 4..7, frame_count=2. frame_ack → frame_valid stays 1 with frame_bank=1. Second ack → frame_valid=0.
- Overflow: with both banks FULL, apply a 9th cap → no buf_wr_en, overflow=1. After an ack, the next cap writes addr 0 and overflow remains 1.
- Partial discard: 2 caps, drop enable for 1 cycle, re-enable, then 4 caps → writes to addr 0,1 then 0..3; frame_count=1.
- Reset mid-frame: assert rst after 3 caps with frame_valid=1 → next cycle all outputs 0. The next 4 caps fill bank 0 from addr 0.
